// File: rtl/edge_monitor.sv
// Multi-channel edge monitor: qualified edge pulses, saturating counts,
// sticky pending/overflow flags and first-event timestamps per channel.
// Optional macro EDGE_MON_SYNC_EN adds a 2-flop din synchronizer.
module edge_monitor #(
   parameter int NCH = 4,
   parameter int CW  = 8,
   parameter int TW  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    din,
   input  logic [2*NCH-1:0]  mode,
   input  logic [NCH-1:0]    ack,
   output logic [NCH-1:0]    rise,
   output logic [NCH-1:0]    fall,
   output logic [NCH-1:0]    pend,
   output logic [NCH-1:0]    ovf,
   output logic [NCH*CW-1:0] cnt,
   output logic [NCH*TW-1:0] stamp,
   output logic [TW-1:0]     now,
   output logic              irq
);

   logic [NCH-1:0] samp;
   logic [1:0]     prime_cnt;
   logic           primed;
   logic [TW-1:0]  now_q;

`ifdef EDGE_MON_SYNC_EN
   // Priming must outlast the synchronizer flush after reset.
   localparam logic [1:0] PRIME_N = 2'd3;

   logic [NCH-1:0] sync1;
   logic [NCH-1:0] sync2;

   // Two-flop synchronizer in front of the edge logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   assign samp = sync2;
`else
   localparam logic [1:0] PRIME_N = 2'd1;

   assign samp = din;
`endif

   assign primed = (prime_cnt == PRIME_N);

   // Count priming cycles after reset release, then hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prime_cnt <= '0;
      end else if (!primed) begin
         prime_cnt <= prime_cnt + 2'd1;
      end
   end

   // Free-running timestamp, wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         now_q <= '0;
      end else begin
         now_q <= now_q + TW'(1);
      end
   end

   assign now = now_q;
   assign irq = |pend;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic          is_one;
      logic          is_zero;
      logic          raw_rise;
      logic          raw_fall;
      logic          q_rise;
      logic          q_fall;
      logic          ev;
      logic          full;
      logic          prev_q;
      logic          rise_q;
      logic          fall_q;
      logic          pend_q;
      logic          ovf_q;
      logic [CW-1:0] cnt_q;
      logic [TW-1:0] stamp_q;

      // Unknown samples are neither 0 nor 1, so they never form edges.
      assign is_one   = (samp[i] === 1'b1);
      assign is_zero  = (samp[i] === 1'b0);
      assign raw_rise = primed & ~prev_q & is_one;
      assign raw_fall = primed & prev_q & is_zero;
      assign q_rise   = raw_rise & mode[2*i];
      assign q_fall   = raw_fall & mode[2*i+1];
      assign ev       = q_rise | q_fall;
      assign full     = &cnt_q;

      // Track the last known level regardless of mode.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            prev_q <= 1'b0;
         end else if (is_one || is_zero) begin
            prev_q <= is_one;
         end
      end

      // Register qualified edges as one-cycle pulses.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            rise_q <= q_rise;
            fall_q <= q_fall;
         end
      end

      // Event bookkeeping; an event in the ack cycle beats the clear.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            stamp_q <= '0;
         end else if (ev && ack[i]) begin
            cnt_q   <= CW'(1);
            pend_q  <= 1'b1;
            ovf_q   <= 1'b0;
            stamp_q <= now_q;
         end else if (ev) begin
            if (full) begin
               ovf_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
            pend_q <= 1'b1;
            if (!pend_q) begin
               stamp_q <= now_q;
            end
         end else if (ack[i]) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
         end
      end

      assign rise[i]             = rise_q;
      assign fall[i]             = fall_q;
      assign pend[i]             = pend_q;
      assign ovf[i]              = ovf_q;
      assign cnt[CW*i +: CW]     = cnt_q;
      assign stamp[TW*i +: TW]   = stamp_q;
   end

endmodule

// File: tb/tb_edge_monitor.sv
// Scoreboard bench for edge_monitor: stimulus queues expected pulses,
// a negedge monitor pops and compares them; status checked directly.
module tb_edge_monitor;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int TW  = 16;
`ifdef EDGE_MON_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int SLIP = LAT - 1;

   logic              clk;
   logic              reset;
   logic [NCH-1:0]    din;
   logic [2*NCH-1:0]  mode;
   logic [NCH-1:0]    ack;
   logic [NCH-1:0]    rise;
   logic [NCH-1:0]    fall;
   logic [NCH-1:0]    pend;
   logic [NCH-1:0]    ovf;
   logic [NCH*CW-1:0] cnt;
   logic [NCH*TW-1:0] stamp;
   logic [TW-1:0]     now;
   logic              irq;

   edge_monitor #(.NCH(NCH), .CW(CW), .TW(TW)) dut (
      .clk(clk), .reset(reset), .din(din), .mode(mode), .ack(ack),
      .rise(rise), .fall(fall), .pend(pend), .ovf(ovf),
      .cnt(cnt), .stamp(stamp), .now(now), .irq(irq)
   );

   typedef struct {
      logic [3:0] r;
      logic [3:0] f;
      int         cyc;
   } exp_t;

   exp_t          sb[$];
   int            n_pass = 0;
   int            n_total = 0;
   int            cyc = 0;
   logic [TW-1:0] tb_now;
   logic [TW-1:0] s_exp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference timestamp model.
   always @(posedge clk or posedge reset) begin
      if (reset) tb_now <= '0;
      else       tb_now <= tb_now + 16'd1;
   end

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
   endtask

   task automatic push(input logic [3:0] r, input logic [3:0] f);
      exp_t e;
      e.r = r;
      e.f = f;
      e.cyc = cyc + LAT;
      sb.push_back(e);
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_now(input logic [TW-1:0] t);
      int g;
      g = 0;
      while (tb_now != t && g < 70000) begin
         @(negedge clk);
         g++;
      end
      chk("wait_now", tb_now, t);
   endtask

   // Monitor: every visible pulse must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && ((rise | fall) != '0)) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_pulse rise=%b fall=%b cyc=%0d",
                     rise, fall, cyc);
         end else begin
            e = sb.pop_front();
            chk("pulse_rise", rise, e.r);
            chk("pulse_fall", fall, e.f);
            chk("pulse_cyc", cyc, e.cyc);
         end
      end
   end

   initial begin
      reset = 1'b1;
      din   = 4'hF;
      mode  = 8'hFF;
      ack   = 4'h0;
      hold(3);
      chk("rst_rise", rise, 0);
      chk("rst_fall", fall, 0);
      chk("rst_pend", pend, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_stamp", stamp, 0);
      chk("rst_now", now, 0);
      chk("rst_irq", irq, 0);
      reset = 1'b0;
      hold(6);
      chk("prime_cnt", cnt, 0);
      chk("prime_pend", pend, 0);
      chk("prime_irq", irq, 0);
      chk("now_run", now, tb_now);

      // Ch0 posedge only, levels held 3 cycles.
      mode = 8'h01;
      din[0] = 1'b0;
      hold(3);
      din[0] = 1'b1;
      s_exp = tb_now + 16'(SLIP);
      push(4'b0001, 4'b0000);
      hold(3);
      din[0] = 1'b0;
      hold(3);
      din[0] = 1'b1;
      push(4'b0001, 4'b0000);
      hold(4);
      chk("c0_cnt", cnt[7:0], 2);
      chk("c0_pend", pend, 4'b0001);
      chk("c0_stamp", stamp[15:0], s_exp);
      chk("c0_irq", irq, 1);
      ack = 4'b0001;
      hold(1);
      ack = 4'b0000;
      chk("c0_ack_cnt", cnt[7:0], 0);
      chk("c0_ack_pend", pend, 0);
      chk("c0_ack_stamp", stamp[15:0], s_exp);

      // Ch1 both edges, saturate at 255 then overflow.
      mode = 8'h0C;
      for (int k = 0; k < 255; k++) begin
         din[1] = ~din[1];
         if (din[1]) push(4'b0010, 4'b0000);
         else        push(4'b0000, 4'b0010);
         @(negedge clk);
      end
      hold(4);
      chk("c1_cnt255", cnt[15:8], 255);
      chk("c1_no_ovf", ovf, 0);
      for (int k = 0; k < 45; k++) begin
         din[1] = ~din[1];
         if (din[1]) push(4'b0010, 4'b0000);
         else        push(4'b0000, 4'b0010);
         @(negedge clk);
      end
      hold(4);
      chk("c1_sat", cnt[15:8], 255);
      chk("c1_ovf", ovf, 4'b0010);
      chk("c1_pend", pend, 4'b0010);
      ack = 4'b0010;
      hold(1);
      ack = 4'b0000;
      chk("c1_ack_cnt", cnt[15:8], 0);
      chk("c1_ack_ovf", ovf, 0);
      chk("c1_ack_pend", pend, 0);

      // Ch2 negedge only: five falls, then a fall coinciding with ack.
      mode = 8'h20;
      for (int k = 0; k < 10; k++) begin
         din[2] = ~din[2];
         if (!din[2]) begin
            if (k == 0) s_exp = tb_now + 16'(SLIP);
            push(4'b0000, 4'b0100);
         end
         @(negedge clk);
      end
      hold(4);
      chk("c2_cnt5", cnt[23:16], 5);
      chk("c2_stamp1", stamp[47:32], s_exp);
      din[2] = 1'b0;
      s_exp = tb_now + 16'(SLIP);
      push(4'b0000, 4'b0100);
      hold(SLIP);
      ack = 4'b0100;
      hold(1);
      ack = 4'b0000;
      hold(4);
      chk("c2_ackev_cnt", cnt[23:16], 1);
      chk("c2_ackev_pend", pend, 4'b0100);
      chk("c2_ackev_ovf", ovf, 0);
      chk("c2_ackev_stamp", stamp[47:32], s_exp);
      ack = 4'b0100;
      hold(1);
      ack = 4'b0000;

      // Timestamp wrap on ch0.
      mode = 8'h01;
      din[0] = 1'b0;
      wait_now(16'hFFFF - 16'(SLIP));
      din[0] = 1'b1;
      push(4'b0001, 4'b0000);
      hold(SLIP + 1);
      chk("wrap_now", now, 0);
      chk("wrap_stamp", stamp[15:0], 16'hFFFF);
      chk("wrap_cnt", cnt[7:0], 1);
      ack = 4'b0001;
      din[0] = 1'b0;
      hold(1);
      ack = 4'b0000;
      chk("wrap_ack_cnt", cnt[7:0], 0);
      wait_now(16'h0003 - 16'(SLIP));
      din[0] = 1'b1;
      push(4'b0001, 4'b0000);
      hold(SLIP + 1);
      chk("wrap_stamp3", stamp[15:0], 16'h0003);
      chk("wrap_pend", pend, 4'b0001);

      // Ch3 both edges, then reset mid-toggle.
      mode = 8'hC0;
      for (int k = 0; k < 7; k++) begin
         din[3] = ~din[3];
         if (din[3]) push(4'b1000, 4'b0000);
         else        push(4'b0000, 4'b1000);
         @(negedge clk);
      end
      hold(4);
      chk("c3_cnt7", cnt[31:24], 7);
      din[3] = ~din[3];
      #2 reset = 1'b1;
      #1;
      chk("mid_rise", rise, 0);
      chk("mid_fall", fall, 0);
      chk("mid_pend", pend, 0);
      chk("mid_ovf", ovf, 0);
      chk("mid_cnt", cnt, 0);
      chk("mid_stamp", stamp, 0);
      chk("mid_now", now, 0);
      chk("mid_irq", irq, 0);
      mode = 8'hFF;
      din = 4'hF;
      hold(2);
      reset = 1'b0;
      hold(6);
      chk("post_cnt", cnt, 0);
      chk("post_pend", pend, 0);
      din[3] = 1'b0;
      s_exp = tb_now + 16'(SLIP);
      push(4'b0000, 4'b1000);
      hold(4);
      chk("post_c3_cnt", cnt[31:24], 1);
      chk("post_c3_stamp", stamp[63:48], s_exp);
      chk("post_irq", irq, 1);

      hold(2);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
